brojac_upisa: RTL and testbench

- Push-side controller for the LIFO stack; the write-end counterpart of the pop/read-more controller.
- Converts a single-cycle push request into one push strobe.
- Converts a write-more request into N paced push strobes of a latched value, one every TICK_COUNT clocks, stopping early on stack full.
- Sits between the debounced/edge-detected button inputs and the stack's push/data_in ports.

---
 rtl/brojac_pkg.sv | 18 +
 rtl/generator_takta.sv | 42 ++++
 rtl/brojac_upisa.sv | 158 +++++++++++++++
 tb/tb_brojac_upisa.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brojac_pkg.sv
// brojac_pkg: shared types and default constants for the stack push-side
// controller (brojac_upisa) and its tick generator (generator_takta).
//   state_t        : controller state (IDLE, ACTIVE)
//   TICK_COUNT_DEF : default clocks between paced pushes (1 s at 100 MHz)
//   CNT_WIDTH_DEF  : default tick counter width, 2^27 >= 100_000_000
//   COUNT_W        : width of the repeat count (0..15)
package brojac_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int TICK_COUNT_DEF = 100000000;
  localparam int CNT_WIDTH_DEF  = 27;
  localparam int COUNT_W        = 4;

endpackage

// File: rtl/generator_takta.sv
// generator_takta: pacing tick counter for the repeated-push sequence.
// Counts up while en is high, wraps from TICK_COUNT-1 to 0 and flags the
// terminal count for that one cycle. clr has priority over en.
// Ports:
//   clk, rst_edge_n : clock, asynchronous active-low reset
//   clr             : synchronous clear to 0
//   en              : count enable
//   tc              : high while enabled and count == TICK_COUNT-1
module generator_takta
  import brojac_pkg::*;
#(
  parameter int TICK_COUNT = TICK_COUNT_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst_edge_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TICK_COUNT - 1);

  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_edge_n) begin
    if (!rst_edge_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign tc = en && (cnt_q == LAST);

endmodule

// File: rtl/brojac_upisa.sv
// brojac_upisa: push-side controller for the LIFO stack.
// A push request yields one registered pisi strobe; a write-more request
// yields count_in paced pisi_vise strobes of a latched value, one every
// TICK_COUNT clocks, aborting on stack_full.
// Build option: define BROJAC_UPISA_AUTO_INC_EN to step data_out by one
// after every pisi_vise (d, d+1, d+2, ... modulo 2^DATA_WIDTH).
// Ports:
//   clk, rst_edge_n  : clock, asynchronous active-low reset
//   push_edge        : single-cycle request, push data_in once
//   write_more_edge  : single-cycle request, start/restart/cancel repeat
//   data_in          : value to push
//   count_in         : number of repeated pushes (0 cancels/ignores)
//   stack_full       : stack full status
//   pisi             : push strobe, single path (one cycle after request)
//   pisi_vise        : push strobe, repeated path
//   data_out         : registered data presented with either strobe
//   busy             : repeated sequence in progress
//   full_drop        : a push was refused because the stack was full
//
// state  | meaning
// IDLE   | waiting for a request, tick counter held at 0
// ACTIVE | repeated sequence running, attempt on every tick terminal
module brojac_upisa
  import brojac_pkg::*;
#(
  parameter int DATA_WIDTH  = 4,
  parameter int STACK_DEPTH = 16,
  parameter int TICK_COUNT  = TICK_COUNT_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_edge_n,
  input  logic                  push_edge,
  input  logic                  write_more_edge,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [COUNT_W-1:0]    count_in,
  input  logic                  stack_full,
  output logic                  pisi,
  output logic                  pisi_vise,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  full_drop
);

  if (STACK_DEPTH < 1 || TICK_COUNT < 1 ||
      (64'd1 << CNT_WIDTH) < 64'(TICK_COUNT)) begin : g_bad_params
    $error("brojac_upisa: invalid STACK_DEPTH/TICK_COUNT/CNT_WIDTH");
  end

  state_t                state_q, state_d;
  logic [COUNT_W-1:0]    rem_q, rem_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  pisi_q, pisi_d;
  logic                  drop_q, drop_d;
  logic                  tick_clr, tick_en, tc;
  logic                  attempt;

  generator_takta #(
    .TICK_COUNT(TICK_COUNT),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_generator_takta (
    .clk       (clk),
    .rst_edge_n(rst_edge_n),
    .clr       (tick_clr),
    .en        (tick_en),
    .tc        (tc)
  );

  assign tick_en = (state_q == ACTIVE);

  always_ff @(posedge clk or negedge rst_edge_n) begin
    if (!rst_edge_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      data_q  <= '0;
      pisi_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      pisi_q  <= pisi_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    data_d   = data_q;
    pisi_d   = 1'b0;
    drop_d   = 1'b0;
    tick_clr = 1'b0;
    case (state_q)
      IDLE: begin
        tick_clr = 1'b1;
        // write_more has priority; a zero count swallows the push as well
        if (write_more_edge) begin
          if (count_in != '0) begin
            if (stack_full) begin
              drop_d = 1'b1;
            end else begin
              state_d = ACTIVE;
              rem_d   = count_in;
              data_d  = data_in;
            end
          end
        end else if (push_edge) begin
          if (stack_full) begin
            drop_d = 1'b1;
          end else begin
            pisi_d = 1'b1;
            data_d = data_in;
          end
        end
      end
      ACTIVE: begin
        if (write_more_edge) begin
          // restart beats a coincident tick terminal
          tick_clr = 1'b1;
          if (count_in == '0) begin
            state_d = IDLE;
          end else begin
            rem_d  = count_in;
            data_d = data_in;
          end
        end else if (tc) begin
          if (stack_full) begin
            state_d = IDLE;
          end else begin
            rem_d = rem_q - 1'b1;
`ifdef BROJAC_UPISA_AUTO_INC_EN
            data_d = data_q + 1'b1;
`endif
            if (rem_q == COUNT_W'(1)) begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Repeated-path outputs are decoded from the live tick so the strobe lands
  // exactly TICK_COUNT cycles after the request and busy falls with it.
  always_comb begin
    attempt   = (state_q == ACTIVE) && tc && !write_more_edge;
    pisi_vise = attempt && !stack_full;
    full_drop = drop_q || (attempt && stack_full);
    busy      = (state_q == ACTIVE) &&
                !(attempt && (stack_full || (rem_q == COUNT_W'(1))));
    pisi      = pisi_q;
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_brojac_upisa.sv
module tb_brojac_upisa;

  localparam int DW = 4;
  localparam int TC = 10;
  localparam int CW = 4;
`ifdef BROJAC_UPISA_AUTO_INC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_edge_n = 1'b0;
  logic          push_edge = 1'b0;
  logic          write_more_edge = 1'b0;
  logic          stack_full = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [3:0]    count_in = '0;
  logic          pisi, pisi_vise, busy, full_drop;
  logic [DW-1:0] data_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  brojac_upisa #(
    .DATA_WIDTH (DW),
    .STACK_DEPTH(16),
    .TICK_COUNT (TC),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .rst_edge_n     (rst_edge_n),
    .push_edge      (push_edge),
    .write_more_edge(write_more_edge),
    .data_in        (data_in),
    .count_in       (count_in),
    .stack_full     (stack_full),
    .pisi           (pisi),
    .pisi_vise      (pisi_vise),
    .data_out       (data_out),
    .busy           (busy),
    .full_drop      (full_drop)
  );

  task automatic test_reset();
    rst_edge_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({pisi, pisi_vise, busy, full_drop, data_out} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {pisi, pisi_vise, busy, full_drop, data_out});
    end
    @(negedge clk);
    rst_edge_n = 1'b1;
  endtask

  task automatic test_single_push();
    @(negedge clk);
    push_edge = 1'b1; data_in = 4'd5;
    @(negedge clk);
    push_edge = 1'b0; data_in = 4'd0;
    #1;
    checks++;
    if ({pisi, pisi_vise, busy, full_drop} !== 4'b1000) begin
      errors++;
      $display("FAIL single_strobes: got %b expected 1000", {pisi, pisi_vise, busy, full_drop});
    end
    checks++;
    if (data_out !== 4'd5) begin
      errors++;
      $display("FAIL single_data: got %0d expected 5", data_out);
    end
    @(negedge clk);
    #1;
    checks++;
    if (pisi !== 1'b0 || data_out !== 4'd5) begin
      errors++;
      $display("FAIL single_after: got pisi=%b data=%0d expected pisi=0 data=5", pisi, data_out);
    end
  endtask

  task automatic test_idle_full();
    @(negedge clk);
    stack_full = 1'b1; push_edge = 1'b1; data_in = 4'd9;
    @(negedge clk);
    push_edge = 1'b0;
    #1;
    checks++;
    if ({pisi, full_drop} !== 2'b01 || data_out !== 4'd5) begin
      errors++;
      $display("FAIL idle_full_push: got pisi=%b drop=%b data=%0d expected pisi=0 drop=1 data=5",
               pisi, full_drop, data_out);
    end
    write_more_edge = 1'b1; count_in = 4'd3;
    @(negedge clk);
    write_more_edge = 1'b0;
    #1;
    checks++;
    if ({busy, full_drop} !== 2'b01) begin
      errors++;
      $display("FAIL idle_full_more: got busy=%b drop=%b expected busy=0 drop=1", busy, full_drop);
    end
    stack_full = 1'b0;
    // zero count: ignored, and the coincident push is discarded too
    write_more_edge = 1'b1; push_edge = 1'b1; count_in = 4'd0; data_in = 4'd7;
    @(negedge clk);
    write_more_edge = 1'b0; push_edge = 1'b0;
    #1;
    checks++;
    if ({pisi, busy, full_drop} !== 3'b000) begin
      errors++;
      $display("FAIL zero_count: got %b expected 000", {pisi, busy, full_drop});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({pisi, pisi_vise, busy, full_drop} !== 4'b0000) begin
      errors++;
      $display("FAIL zero_count_after: got %b expected 0000", {pisi, pisi_vise, busy, full_drop});
    end
  endtask

  task automatic test_repeat(input logic [3:0] d, input logic [3:0] n);
    logic       exp_v, exp_b;
    logic [3:0] exp_d;
    int         pulses;
    pulses = 0;
    @(negedge clk);
    write_more_edge = 1'b1; data_in = d; count_in = n;
    for (int k = 1; k <= int'(n) * TC + 5; k++) begin
      @(negedge clk);
      write_more_edge = 1'b0; data_in = 4'd0; count_in = 4'd0;
      #1;
      exp_v = (k % TC == 0) && (k <= int'(n) * TC);
      exp_b = (k < int'(n) * TC);
      checks++;
      if (pisi_vise !== exp_v || busy !== exp_b || pisi !== 1'b0) begin
        errors++;
        $display("FAIL repeat_d%0d k=%0d: got vise=%b busy=%b pisi=%b expected vise=%b busy=%b pisi=0",
                 d, k, pisi_vise, busy, pisi, exp_v, exp_b);
      end
      if (pisi_vise === 1'b1) pulses++;
      if (exp_v) begin
        exp_d = d + (AUTO ? 4'(k / TC - 1) : 4'd0);
        checks++;
        if (data_out !== exp_d) begin
          errors++;
          $display("FAIL repeat_data_d%0d k=%0d: got %0d expected %0d", d, k, data_out, exp_d);
        end
      end
    end
    checks++;
    if (pulses != int'(n)) begin
      errors++;
      $display("FAIL repeat_pulses_d%0d: got %0d expected %0d", d, pulses, n);
    end
  endtask

  task automatic test_full_abort();
    logic exp_v, exp_drop, exp_b;
    @(negedge clk);
    write_more_edge = 1'b1; data_in = 4'd9; count_in = 4'd5;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      write_more_edge = 1'b0; count_in = 4'd0;
      stack_full = (k > 20);
      #1;
      exp_v = (k == 10) || (k == 20);
      exp_drop = (k == 30);
      exp_b = (k < 30);
      checks++;
      if (pisi_vise !== exp_v || full_drop !== exp_drop || busy !== exp_b) begin
        errors++;
        $display("FAIL full_abort k=%0d: got vise=%b drop=%b busy=%b expected vise=%b drop=%b busy=%b",
                 k, pisi_vise, full_drop, busy, exp_v, exp_drop, exp_b);
      end
    end
    stack_full = 1'b0;
  endtask

  task automatic test_collisions();
    logic       exp_v, exp_b;
    logic [3:0] exp_d;
    @(negedge clk);
    write_more_edge = 1'b1; push_edge = 1'b1; data_in = 4'd6; count_in = 4'd2;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      write_more_edge = 1'b0; count_in = 4'd0;
      push_edge = (k == 5);
      data_in = (k == 5) ? 4'hA : 4'd0;
      #1;
      exp_v = (k == 10) || (k == 20);
      exp_b = (k < 20);
      checks++;
      if (pisi !== 1'b0 || full_drop !== 1'b0 || pisi_vise !== exp_v || busy !== exp_b) begin
        errors++;
        $display("FAIL collide k=%0d: got pisi=%b drop=%b vise=%b busy=%b expected 0 0 %b %b",
                 k, pisi, full_drop, pisi_vise, busy, exp_v, exp_b);
      end
      if (exp_v) begin
        exp_d = 4'd6 + ((AUTO && k == 20) ? 4'd1 : 4'd0);
        checks++;
        if (data_out !== exp_d) begin
          errors++;
          $display("FAIL collide_data k=%0d: got %0d expected %0d", k, data_out, exp_d);
        end
      end
    end
    push_edge = 1'b0;
    // cancel with a zero count while busy
    @(negedge clk);
    write_more_edge = 1'b1; data_in = 4'd2; count_in = 4'd3;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      write_more_edge = (k == 5); count_in = 4'd0;
      #1;
      checks++;
      if (busy !== (k <= 5) || pisi_vise !== 1'b0) begin
        errors++;
        $display("FAIL cancel k=%0d: got busy=%b vise=%b expected busy=%b vise=0",
                 k, busy, pisi_vise, (k <= 5));
      end
    end
    write_more_edge = 1'b0;
  endtask

  task automatic test_restart();
    @(negedge clk);
    write_more_edge = 1'b1; data_in = 4'd1; count_in = 4'd3;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      write_more_edge = (k == 5);
      data_in = (k == 5) ? 4'd8 : 4'd0;
      count_in = (k == 5) ? 4'd1 : 4'd0;
      #1;
      checks++;
      if (pisi_vise !== (k == 15) || busy !== (k < 15)) begin
        errors++;
        $display("FAIL restart k=%0d: got vise=%b busy=%b expected vise=%b busy=%b",
                 k, pisi_vise, busy, (k == 15), (k < 15));
      end
      if (k == 15) begin
        checks++;
        if (data_out !== 4'd8) begin
          errors++;
          $display("FAIL restart_data: got %0d expected 8", data_out);
        end
      end
    end
    write_more_edge = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    write_more_edge = 1'b1; data_in = 4'd4; count_in = 4'd3;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      write_more_edge = 1'b0; count_in = 4'd0; data_in = 4'd0;
      #1;
      checks++;
      if (pisi_vise !== (k == 10) || busy !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_pre k=%0d: got vise=%b busy=%b expected vise=%b busy=1",
                 k, pisi_vise, busy, (k == 10));
      end
    end
    @(negedge clk);
    rst_edge_n = 1'b0;
    #1;
    checks++;
    if ({pisi, pisi_vise, busy, full_drop, data_out} !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_async: got %b expected 00000000",
               {pisi, pisi_vise, busy, full_drop, data_out});
    end
    @(negedge clk);
    rst_edge_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (pisi_vise !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_post k=%0d: got vise=%b busy=%b expected 0 0", k, pisi_vise, busy);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_push();
    test_idle_full();
    test_repeat(4'd3, 4'd4);
    test_repeat(4'd14, 4'd4);
    test_full_abort();
    test_collisions();
    test_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
